// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - state encoding, opcodes, ALU op codes and mux selects for the multicycle control
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_EXEC_R = 4'd3,
      S_EXEC_I = 4'd4,
      S_ALUWB  = 4'd5,
      S_MEMADR = 4'd6,
      S_MEMRD  = 4'd7,
      S_MEMWB  = 4'd8,
      S_MEMWR  = 4'd9,
      S_BRANCH = 4'd10,
      S_JUMP   = 4'd11,
      S_JAL    = 4'd12,
      S_HALT   = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_NOR  = 4'b0100;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLTU = 4'b0111;
   localparam logic [3:0] ALU_SLT  = 4'b1000;
   localparam logic [3:0] ALU_LUI  = 4'b1100;

   localparam logic [1:0] REGDST_RT   = 2'b00;
   localparam logic [1:0] REGDST_RD   = 2'b01;
   localparam logic [1:0] REGDST_RA   = 2'b10;
   localparam logic [1:0] MTR_ALUOUT  = 2'b00;
   localparam logic [1:0] MTR_MDR     = 2'b01;
   localparam logic [1:0] MTR_PC      = 2'b10;
   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMMSH  = 2'b11;
   localparam logic [1:0] PCSRC_ALU   = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP  = 2'b10;

   function automatic logic [3:0] imm_alu_op(input logic [5:0] op);
      case (op)
         OP_ANDI:  return ALU_AND;
         OP_ORI:   return ALU_OR;
         OP_XORI:  return ALU_XOR;
         OP_SLTI:  return ALU_SLT;
         OP_SLTIU: return ALU_SLTU;
         OP_LUI:   return ALU_LUI;
         default:  return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_multiciclo_if.sv
// rtl/ctrl_multiciclo_if.sv - memory request/ready handshake between control and memory
interface ctrl_multiciclo_if;
   logic MemRead;
   logic MemWrite;
   logic IorD;
   logic MemReady;

   modport master (output MemRead, output MemWrite, output IorD, input MemReady);
   modport slave  (input MemRead, input MemWrite, input IorD, output MemReady);
endinterface

// File: rtl/ctrl_mem_watchdog.sv
// rtl/ctrl_mem_watchdog.sv - counts cycles spent waiting on MemReady; sticky timeout flag
module ctrl_mem_watchdog #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic waiting,
   input  logic mem_ready,
   output logic expired,
   output logic timeout
);

   localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   logic [CW-1:0] count;

   // Leaving the wait states clears the count, so every entry starts from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (!waiting || mem_ready || MEM_TIMEOUT == 0)
         count <= '0;
      else
         count <= count + 1'b1;
   end

   generate
      if (MEM_TIMEOUT == 0) begin : g_off
         assign expired = 1'b0;
      end else begin : g_on
         assign expired = waiting && !mem_ready && (count == CW'(MEM_TIMEOUT));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         timeout <= 1'b0;
      else if (expired)
         timeout <= 1'b1;
   end

endmodule

// File: rtl/ctrl_multiciclo.sv
// rtl/ctrl_multiciclo.sv - multicycle MIPS main control FSM
// CTRL_MC_TRAP_EN: undefined opcodes set IllegalOp and halt instead of executing as NOP.
module ctrl_multiciclo
   import ctrl_pkg::*;
#(
   parameter int ALUOP_W     = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst_n,
   ctrl_multiciclo_if.master  mem,
   input  logic [5:0]         OPCode,
   input  logic               Zero,
   output logic               PCWrite,
   output logic               IRWrite,
   output logic [1:0]         RegDst,
   output logic [1:0]         MemtoReg,
   output logic               RegWrite,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         PCSrc,
   output logic               ALUTipoR,
   output logic [ALUOP_W-1:0] ALUnaoR,
   output logic               InstrDone,
   output logic               MemTimeout,
   output logic               IllegalOp,
   output logic [3:0]         State
);

   state_t     state, state_nxt;
   logic [3:0] alu_op;
   logic       in_mem, wd_expired;

   assign in_mem  = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
   assign ALUnaoR = ALUOP_W'(alu_op);
   assign State   = state;

   ctrl_mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_watchdog (
      .clk       (clk),
      .rst_n     (rst_n),
      .waiting   (in_mem),
      .mem_ready (mem.MemReady),
      .expired   (wd_expired),
      .timeout   (MemTimeout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

`ifdef CTRL_MC_TRAP_EN
   logic illegal_q;
   // DECODE only heads to HALT for an undefined opcode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         illegal_q <= 1'b0;
      else if (state == S_DECODE && state_nxt == S_HALT)
         illegal_q <= 1'b1;
   end
   assign IllegalOp = illegal_q;
`else
   assign IllegalOp = 1'b0;
`endif

   always_comb begin
      state_nxt    = state;
      PCWrite      = 1'b0;
      IRWrite      = 1'b0;
      RegDst       = REGDST_RT;
      MemtoReg     = MTR_ALUOUT;
      RegWrite     = 1'b0;
      ALUSrcA      = 1'b0;
      ALUSrcB      = SRCB_RT;
      PCSrc        = PCSRC_ALU;
      ALUTipoR     = 1'b0;
      alu_op       = 4'b0000;
      InstrDone    = 1'b0;
      mem.MemRead  = 1'b0;
      mem.MemWrite = 1'b0;
      mem.IorD     = 1'b0;
      case (state)
         S_IDLE: state_nxt = S_FETCH;
         S_FETCH: begin
            mem.MemRead = 1'b1;
            ALUSrcB     = SRCB_FOUR;
            alu_op      = ALU_ADD;
            if (mem.MemReady) begin
               IRWrite   = 1'b1;
               PCWrite   = 1'b1;
               state_nxt = S_DECODE;
            end else if (wd_expired) begin
               state_nxt = S_HALT;
            end
         end
         S_DECODE: begin
            ALUSrcB = SRCB_IMMSH;
            alu_op  = ALU_ADD;
            case (OPCode)
               OP_RTYPE: state_nxt = S_EXEC_R;
               OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
               OP_SLTI, OP_SLTIU, OP_LUI: state_nxt = S_EXEC_I;
               OP_LW, OP_SW:   state_nxt = S_MEMADR;
               OP_BEQ, OP_BNE: state_nxt = S_BRANCH;
               OP_J:           state_nxt = S_JUMP;
               OP_JAL:         state_nxt = S_JAL;
               default: begin
`ifdef CTRL_MC_TRAP_EN
                  state_nxt = S_HALT;
`else
                  InstrDone = 1'b1;
                  state_nxt = S_FETCH;
`endif
               end
            endcase
         end
         S_EXEC_R: begin
            ALUSrcA   = 1'b1;
            ALUTipoR  = 1'b1;
            state_nxt = S_ALUWB;
         end
         S_EXEC_I: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_IMM;
            alu_op    = imm_alu_op(OPCode);
            state_nxt = S_ALUWB;
         end
         S_ALUWB: begin
            // ALU inputs stay as in EXEC so ALUOut is unaffected by the extra cycle.
            ALUSrcA   = 1'b1;
            RegWrite  = 1'b1;
            InstrDone = 1'b1;
            state_nxt = S_FETCH;
            if (OPCode == OP_RTYPE) begin
               ALUTipoR = 1'b1;
               RegDst   = REGDST_RD;
            end else begin
               ALUSrcB = SRCB_IMM;
               alu_op  = imm_alu_op(OPCode);
            end
         end
         S_MEMADR: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = SRCB_IMM;
            alu_op    = ALU_ADD;
            state_nxt = (OPCode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            mem.MemRead = 1'b1;
            mem.IorD    = 1'b1;
            if (mem.MemReady)     state_nxt = S_MEMWB;
            else if (wd_expired)  state_nxt = S_HALT;
         end
         S_MEMWB: begin
            MemtoReg  = MTR_MDR;
            RegWrite  = 1'b1;
            InstrDone = 1'b1;
            state_nxt = S_FETCH;
         end
         S_MEMWR: begin
            mem.MemWrite = 1'b1;
            mem.IorD     = 1'b1;
            if (mem.MemReady) begin
               InstrDone = 1'b1;
               state_nxt = S_FETCH;
            end else if (wd_expired) begin
               state_nxt = S_HALT;
            end
         end
         S_BRANCH: begin
            // OPCode[0] distinguishes bne from beq.
            ALUSrcA   = 1'b1;
            alu_op    = ALU_SUB;
            PCSrc     = PCSRC_ALUOUT;
            PCWrite   = Zero ^ OPCode[0];
            InstrDone = 1'b1;
            state_nxt = S_FETCH;
         end
         S_JUMP, S_JAL: begin
            PCSrc     = PCSRC_JUMP;
            PCWrite   = 1'b1;
            InstrDone = 1'b1;
            state_nxt = S_FETCH;
            if (state == S_JAL) begin
               RegWrite = 1'b1;
               RegDst   = REGDST_RA;
               MemtoReg = MTR_PC;
            end
         end
         S_HALT:  state_nxt = S_HALT;
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_ctrl_multiciclo.sv
// tb/tb_ctrl_multiciclo.sv - randomized instruction stream against a per-instruction step model
module tb_ctrl_multiciclo;
   import ctrl_pkg::*;

   localparam int K_FETCH = 0, K_DECODE = 1, K_EXEC = 2, K_WB = 3, K_ADDR = 4,
                  K_RD = 5, K_MEMWB = 6, K_WR = 7, K_BR = 8, K_J = 9;

   localparam logic [5:0] LEGAL [0:14] = '{6'o00, 6'o10, 6'o14, 6'o15, 6'o16, 6'o12, 6'o13,
                                           6'o17, 6'o43, 6'o53, 6'o04, 6'o05, 6'o02, 6'o03, 6'o03};

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] OPCode = '0;
   logic       Zero = 1'b0;
   logic       PCWrite, IRWrite, RegWrite, ALUSrcA, ALUTipoR, InstrDone, MemTimeout, IllegalOp;
   logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSrc;
   logic [3:0] ALUnaoR, State;
   logic [20:0] obs;
   int vectors = 0;
   int miscompares = 0;

   ctrl_multiciclo_if mif ();

   ctrl_multiciclo #(.ALUOP_W(4), .MEM_TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n), .mem(mif), .OPCode(OPCode), .Zero(Zero),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
      .ALUTipoR(ALUTipoR), .ALUnaoR(ALUnaoR), .InstrDone(InstrDone),
      .MemTimeout(MemTimeout), .IllegalOp(IllegalOp), .State(State)
   );

   always #5 clk = ~clk;

   assign obs = {PCWrite, mif.IorD, mif.MemRead, mif.MemWrite, IRWrite, RegDst, MemtoReg,
                 RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALUTipoR, ALUnaoR, InstrDone};

   function automatic bit is_legal(input logic [5:0] op);
      foreach (LEGAL[i]) if (LEGAL[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit is_itype(input logic [5:0] op);
      return op inside {6'o10, 6'o14, 6'o15, 6'o16, 6'o12, 6'o13, 6'o17};
   endfunction

   // ALU operation each immediate instruction performs.
   function automatic logic [3:0] imm_op(input logic [5:0] op);
      case (op)
         6'o10: return 4'd2;
         6'o14: return 4'd0;
         6'o15: return 4'd1;
         6'o16: return 4'd3;
         6'o12: return 4'd8;
         6'o13: return 4'd7;
         default: return 4'd12;
      endcase
   endfunction

   // Control word the datapath needs for one step of an instruction.
   function automatic logic [20:0] expw(input int k, input logic [5:0] op, input logic rdy, input logic z);
      logic pcw = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, rw = 0, srca = 0, tipor = 0, done = 0;
      logic [1:0] rdst = 0, mtr = 0, srcb = 0, pcs = 0;
      logic [3:0] alu = 0;
      case (k)
         K_FETCH:  begin mrd = 1; srcb = 1; alu = 2; pcw = rdy; irw = rdy; end
         K_DECODE: begin
            srcb = 3; alu = 2;
`ifndef CTRL_MC_TRAP_EN
            done = !is_legal(op);
`endif
         end
         K_EXEC, K_WB: begin
            srca = 1;
            if (op == 0) tipor = 1;
            else begin srcb = 2; alu = imm_op(op); end
            if (k == K_WB) begin rw = 1; done = 1; rdst = (op == 0) ? 2'd1 : 2'd0; end
         end
         K_ADDR:  begin srca = 1; srcb = 2; alu = 2; end
         K_RD:    begin mrd = 1; iord = 1; end
         K_MEMWB: begin mtr = 1; rw = 1; done = 1; end
         K_WR:    begin mwr = 1; iord = 1; done = rdy; end
         K_BR:    begin srca = 1; alu = 6; pcs = 1; done = 1; pcw = (op == 6'o04) ? z : !z; end
         default: begin
            pcs = 2; pcw = 1; done = 1;
            if (op == 6'o03) begin rw = 1; rdst = 2; mtr = 2; end
         end
      endcase
      return {pcw, iord, mrd, mwr, irw, rdst, mtr, rw, srca, srcb, pcs, tipor, alu, done};
   endfunction

   task automatic check(input string tag, input logic [20:0] got, input logic [20:0] want);
      vectors++;
      assert (got === want) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask

   task automatic step(input int k, input logic [5:0] op, input logic rdy, input string tag);
      @(negedge clk);
      mif.MemReady = rdy;
      OPCode = (k == K_FETCH) ? 6'($urandom) : op;
      Zero = 1'($urandom);
      #1;
      check(tag, obs, expw(k, op, rdy, Zero));
   endtask

   task automatic mem_step(input int k, input logic [5:0] op, input int waits, input string tag);
      for (int i = 0; i < waits; i++) step(k, op, 1'b0, tag);
      step(k, op, 1'b1, tag);
   endtask

   task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
      string t;
      t = $sformatf("op%02o", op);
      mem_step(K_FETCH, op, wf, {t, "_fetch"});
      step(K_DECODE, op, 1'($urandom), {t, "_decode"});
      if (op == 0 || is_itype(op)) begin
         step(K_EXEC, op, 1'($urandom), {t, "_exec"});
         step(K_WB, op, 1'($urandom), {t, "_wb"});
      end else if (op == 6'o43) begin
         step(K_ADDR, op, 1'($urandom), {t, "_addr"});
         mem_step(K_RD, op, wm, {t, "_memrd"});
         step(K_MEMWB, op, 1'($urandom), {t, "_memwb"});
      end else if (op == 6'o53) begin
         step(K_ADDR, op, 1'($urandom), {t, "_addr"});
         mem_step(K_WR, op, wm, {t, "_memwr"});
      end else if (op == 6'o04 || op == 6'o05) begin
         step(K_BR, op, 1'($urandom), {t, "_branch"});
      end else if (op == 6'o02 || op == 6'o03) begin
         step(K_J, op, 1'($urandom), {t, "_jump"});
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("reset_outputs", obs, '0);
      check("reset_state_flags", {13'd0, State, MemTimeout, IllegalOp, 2'b0}, {13'd0, S_IDLE, 4'b0});
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("release_idle", {obs[20:4], State}, {17'd0, S_IDLE});
   endtask

   initial begin
      logic [5:0] op;
      mif.MemReady = 1'b0;
      do_reset();

      run_instr(6'o00, 0, 0);
      run_instr(6'o43, 0, 3);
      run_instr(6'o04, 0, 0);
      run_instr(6'o05, 0, 0);
      run_instr(6'o03, 0, 0);
      run_instr(6'o53, 2, 1);
      run_instr(6'o17, 15, 0);
      run_instr(6'o43, 1, 15);
`ifndef CTRL_MC_TRAP_EN
      run_instr(6'o77, 0, 0);
      check("illegal_flag_off", {20'd0, IllegalOp}, '0);
`endif

      for (int n = 0; n < 40; n++) begin
         op = LEGAL[$urandom_range(0, 14)];
`ifndef CTRL_MC_TRAP_EN
         if ($urandom_range(0, 9) == 0) op = 6'($urandom);
`endif
         run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
      end

      mem_step(K_FETCH, 6'o43, 0, "rst_mid_fetch");
      step(K_DECODE, 6'o43, 1'b0, "rst_mid_decode");
      step(K_ADDR, 6'o43, 1'b0, "rst_mid_addr");
      step(K_RD, 6'o43, 1'b0, "rst_mid_memrd");
      step(K_RD, 6'o43, 1'b0, "rst_mid_memrd");
      do_reset();
      run_instr(6'o00, 0, 0);

      for (int i = 0; i < 16; i++) begin
         step(K_FETCH, 6'o00, 1'b0, "wd_wait");
         check("wd_not_yet", {20'd0, MemTimeout}, '0);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         mif.MemReady = 1'($urandom);
         #1;
         check("halt_outputs", obs, '0);
         check("halt_state_flag", {16'd0, State, MemTimeout}, {16'd0, S_HALT, 1'b1});
      end
      do_reset();

`ifdef CTRL_MC_TRAP_EN
      mem_step(K_FETCH, 6'o77, 0, "trap_fetch");
      step(K_DECODE, 6'o77, 1'b1, "trap_decode");
      @(negedge clk);
      #1;
      check("trap_halt", {obs, State, IllegalOp}, {21'd0, S_HALT, 1'b1});
      do_reset();
`endif
      run_instr(6'o10, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
